// File: rtl/pulse_tx_pkg.sv
// Shared types and default constants for the pulse handshake transmitter.
// Holds the FSM state encoding and the default parameter values used by the top level.
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int unsigned DEF_PEND_W         = 4;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/pulse_handshake_tx_sync.sv
// Level synchronizer (sync_level_ff) that brings the far-domain acknowledge into clk.
// It is a plain shift chain reset to 0; fewer than two stages is promoted to two.
module sync_level_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Four-phase request/acknowledge transmitter with a pending-event queue counter.
// Defining PULSE_TX_TIMEOUT_EN adds a per-phase timeout that abandons a stuck handshake.
module pulse_handshake_tx
  import pulse_tx_pkg::*;
#(
  parameter int unsigned PEND_W         = DEF_PEND_W,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pulse,
  input  logic              i_ack,
  input  logic              i_clr_ovf,
  output logic              o_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow,
  output logic              o_timeout
);

  state_t            state, state_next;
  logic [PEND_W-1:0] pending;
  logic              ack_s;
  logic              start_idle, inc_req, dec_req, clr_req, ovf_set;
  logic              done_next, timeout_next, done_q, timeout_q, overflow_q;

  sync_level_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_ack),
    .q   (ack_s)
  );

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] phase_cnt;
  logic             aborted;
  logic             phase_expired;

  assign phase_expired = (phase_cnt == CNT_LAST);

  // Phase counter restarts whenever the FSM changes state; aborted marks a
  // RELEASE phase entered by timeout so its exit does not count as a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
      aborted   <= 1'b0;
    end else begin
      if (state_next != state) begin
        phase_cnt <= '0;
      end else if (state != IDLE && !phase_expired) begin
        phase_cnt <= phase_cnt + CNT_W'(1);
      end
      if (state == REQ && state_next == RELEASE) begin
        aborted <= timeout_next;
      end
    end
  end
`else
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    dec_req      = 1'b0;
    clr_req      = 1'b0;
    case (state)
      IDLE: begin
        if (i_pulse && pending == '0) state_next = REQ;
      end
      REQ: begin
        if (ack_s) begin
          state_next = RELEASE;
`ifdef PULSE_TX_TIMEOUT_EN
        end else if (phase_expired) begin
          state_next   = RELEASE;
          timeout_next = 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (!ack_s) begin
`ifdef PULSE_TX_TIMEOUT_EN
          done_next = !aborted;
`else
          done_next = 1'b1;
`endif
          if (pending != '0) begin
            dec_req    = 1'b1;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
`ifdef PULSE_TX_TIMEOUT_EN
        end else if (phase_expired) begin
          timeout_next = 1'b1;
          clr_req      = 1'b1;
          state_next   = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_idle = (state == IDLE) && i_pulse && (pending == '0);
  assign inc_req    = i_pulse && !start_idle;
  assign ovf_set    = inc_req && !dec_req && (pending == '1);

  // A strobe that lands on the same edge as a dequeue cancels it out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state     <= state_next;
      done_q    <= done_next;
      timeout_q <= timeout_next;
      if (clr_req) begin
        pending <= '0;
      end else if (inc_req && !dec_req && pending != '1) begin
        pending <= pending + PEND_W'(1);
      end else if (dec_req && !inc_req) begin
        pending <= pending - PEND_W'(1);
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (i_clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign o_req      = (state == REQ);
  assign o_busy     = (state != IDLE) || (pending != '0);
  assign o_done     = done_q;
  assign o_pending  = pending;
  assign o_overflow = overflow_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed self-checking bench for pulse_handshake_tx (default and PEND_W=2 instances).
// The timeout scenario is compiled only when PULSE_TX_TIMEOUT_EN is defined.
module tb_pulse_handshake_tx;

  logic       clk = 1'b0;
  logic       rst, i_pulse, i_ack, i_clr_ovf;
  logic       loop_en, ack_force;
  logic [2:0] ack_dly = 3'b000;
  logic       o_req, o_busy, o_done, o_overflow, o_timeout;
  logic [3:0] o_pending;
  logic       s_pulse, s_clr;
  logic       s_req, s_busy, s_done, s_overflow, s_timeout;
  logic [1:0] s_pending;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ack_dly <= {ack_dly[1:0], o_req};
  assign i_ack = loop_en ? ack_dly[2] : ack_force;

  pulse_handshake_tx #(.PEND_W(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_pulse(i_pulse), .i_ack(i_ack), .i_clr_ovf(i_clr_ovf),
    .o_req(o_req), .o_busy(o_busy), .o_done(o_done), .o_pending(o_pending),
    .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  pulse_handshake_tx #(.PEND_W(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut_small (
    .clk(clk), .rst(rst), .i_pulse(s_pulse), .i_ack(1'b0), .i_clr_ovf(s_clr),
    .o_req(s_req), .o_busy(s_busy), .o_done(s_done), .o_pending(s_pending),
    .o_overflow(s_overflow), .o_timeout(s_timeout)
  );

  task automatic do_reset();
    rst = 1'b1; i_pulse = 1'b0; i_clr_ovf = 1'b0; s_pulse = 1'b0; s_clr = 1'b0;
    ack_force = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe_gapped(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) i_pulse = 1'b1;
      @(negedge clk) i_pulse = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({o_req, o_done, o_overflow, o_timeout, o_busy} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", {o_req, o_done, o_overflow, o_timeout, o_busy});
    end
    checks++; if (o_pending !== 4'd0) begin
      fails++; $display("[TB] FAIL reset_pending: got %0d expected 0", o_pending);
    end
    checks++; if ({s_req, s_done, s_overflow, s_timeout, s_pending} !== 6'b0) begin
      fails++; $display("[TB] FAIL reset_small: got %b expected 000000", {s_req, s_done, s_overflow, s_timeout, s_pending});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_pulse();
    int dones = 0, pend_bad = 0;
    do_reset();
    loop_en = 1'b1;
    @(negedge clk) i_pulse = 1'b1;
    @(negedge clk) i_pulse = 1'b0;
    checks++; if (o_req !== 1'b1) begin
      fails++; $display("[TB] FAIL single_req_latency: got %b expected 1", o_req);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done === 1'b1) dones++;
      if (o_pending !== 4'd0) pend_bad++;
    end
    checks++; if (dones != 1) begin
      fails++; $display("[TB] FAIL single_done_count: got %0d expected 1", dones);
    end
    checks++; if (pend_bad != 0) begin
      fails++; $display("[TB] FAIL single_pending_zero: got %0d nonzero cycles expected 0", pend_bad);
    end
    checks++; if (o_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL single_busy_idle: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, rises = 0, peak = 0;
    logic prev_req = 1'b0;
    do_reset();
    loop_en = 1'b1;
    @(negedge clk) i_pulse = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (c == 4) i_pulse = 1'b0;
      if (o_done === 1'b1) dones++;
      if (o_req === 1'b1 && prev_req === 1'b0) rises++;
      if (int'(o_pending) > peak) peak = int'(o_pending);
      prev_req = o_req;
    end
    checks++; if (peak != 4) begin
      fails++; $display("[TB] FAIL b2b_pending_peak: got %0d expected 4", peak);
    end
    checks++; if (dones != 5) begin
      fails++; $display("[TB] FAIL b2b_done_count: got %0d expected 5", dones);
    end
    checks++; if (rises != 5) begin
      fails++; $display("[TB] FAIL b2b_req_rises: got %0d expected 5", rises);
    end
    checks++; if (o_overflow !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_end_state: got ovf=%b busy=%b expected 0 0", o_overflow, o_busy);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_pend [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) s_pulse = 1'b1;
      @(negedge clk) s_pulse = 1'b0;
      checks++; if (s_pending !== exp_pend[k]) begin
        fails++; $display("[TB] FAIL ovf_pending_%0d: got %0d expected %0d", k, s_pending, exp_pend[k]);
      end
      checks++; if (s_overflow !== (k == 4)) begin
        fails++; $display("[TB] FAIL ovf_flag_%0d: got %b expected %b", k, s_overflow, (k == 4));
      end
    end
    repeat (4) @(negedge clk);
    checks++; if (s_overflow !== 1'b1) begin
      fails++; $display("[TB] FAIL ovf_sticky: got %b expected 1", s_overflow);
    end
    @(negedge clk) s_clr = 1'b1;
    @(negedge clk) s_clr = 1'b0;
    checks++; if (s_overflow !== 1'b0) begin
      fails++; $display("[TB] FAIL ovf_clear: got %b expected 0", s_overflow);
    end
    @(negedge clk) begin s_clr = 1'b1; s_pulse = 1'b1; end
    @(negedge clk) begin s_clr = 1'b0; s_pulse = 1'b0; end
    checks++; if (s_overflow !== 1'b1 || s_pending !== 2'd3) begin
      fails++; $display("[TB] FAIL ovf_set_wins: got ovf=%b pend=%0d expected 1 3", s_overflow, s_pending);
    end
  endtask

  task automatic test_coincident_decrement();
    int waited = 0;
    do_reset();
    strobe_gapped(3);
    checks++; if (o_pending !== 4'd2 || o_req !== 1'b1) begin
      fails++; $display("[TB] FAIL coinc_setup: got pend=%0d req=%b expected 2 1", o_pending, o_req);
    end
    ack_force = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (o_req !== 1'b0 && waited < 10);
    checks++; if (o_req !== 1'b0) begin
      fails++; $display("[TB] FAIL coinc_release_wait: got req=%b expected 0 within 10 cycles", o_req);
    end
    ack_force = 1'b0;
    @(negedge clk);
    @(negedge clk) i_pulse = 1'b1;
    @(negedge clk) i_pulse = 1'b0;
    checks++; if (o_done !== 1'b1 || o_pending !== 4'd2 || o_req !== 1'b1) begin
      fails++; $display("[TB] FAIL coinc_exit: got done=%b pend=%0d req=%b expected 1 2 1", o_done, o_pending, o_req);
    end
    @(negedge clk);
    checks++; if (o_done !== 1'b0 || o_overflow !== 1'b0) begin
      fails++; $display("[TB] FAIL coinc_single_done: got done=%b ovf=%b expected 0 0", o_done, o_overflow);
    end
  endtask

  task automatic test_reset_mid_handshake();
    int dones = 0;
    do_reset();
    strobe_gapped(4);
    checks++; if (o_pending !== 4'd3 || o_req !== 1'b1) begin
      fails++; $display("[TB] FAIL rstmid_setup: got pend=%0d req=%b expected 3 1", o_pending, o_req);
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if (o_req !== 1'b0 || o_pending !== 4'd0 || o_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL rstmid_clear: got req=%b pend=%0d busy=%b expected 0 0 0", o_req, o_pending, o_busy);
    end
    if (o_done === 1'b1) dones++;
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_done === 1'b1) dones++;
    end
    checks++; if (dones != 0 || o_req !== 1'b0) begin
      fails++; $display("[TB] FAIL rstmid_no_done: got dones=%0d req=%b expected 0 0", dones, o_req);
    end
  endtask

`ifdef PULSE_TX_TIMEOUT_EN
  task automatic test_timeout();
    int first_to = 0, to_cnt = 0, dones = 0;
    logic req_at_to = 1'b1;
    do_reset();
    @(negedge clk) i_pulse = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) i_pulse = 1'b0;
      if (o_timeout === 1'b1) begin
        to_cnt++;
        if (first_to == 0) begin first_to = i; req_at_to = o_req; end
      end
      if (o_done === 1'b1) dones++;
    end
    checks++; if (first_to != 17) begin
      fails++; $display("[TB] FAIL timeout_cycle: got %0d expected 17", first_to);
    end
    checks++; if (to_cnt != 1 || req_at_to !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_pulse: got count=%0d req=%b expected 1 0", to_cnt, req_at_to);
    end
    checks++; if (dones != 0 || o_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_idle: got dones=%0d busy=%b expected 0 0", dones, o_busy);
    end
  endtask
`else
  task automatic test_timeout();
    int to_seen = 0;
    do_reset();
    strobe_gapped(1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_timeout !== 1'b0) to_seen++;
    end
    checks++; if (to_seen != 0 || o_req !== 1'b1) begin
      fails++; $display("[TB] FAIL no_timeout_wait: got timeouts=%0d req=%b expected 0 1", to_seen, o_req);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_overflow();
    test_coincident_decrement();
    test_reset_mid_handshake();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
